// File: rtl/pipeline_clk_ctrl_pkg.sv
// Shared definitions for the CPU clock-enable controller: FSM state encoding,
// default timing parameters and counter widths.
package pipeline_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } clk_state_t;

  // 100 MHz sysclk / 18 gives the free-run CPU tick rate.
  localparam int DEF_DIV       = 18;
  // 50000 cycles at 100 MHz is a 0.5 ms settle window for the push-button.
  localparam int DEF_DB_CYCLES = 50000;

  localparam int CNT_W  = 16;  // divider width, DIV up to 65535
  localparam int DB_W   = 20;  // debounce counter width, DB_CYCLES up to 2^20-1
  localparam int TICK_W = 32;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-FF synchronizer followed by a debouncer.
// Ports:
//   sysclk - system clock, rising edge
//   reset  - asynchronous active-high reset
//   raw    - raw asynchronous button input (1 = pressed)
//   level  - debounced button level
//   rise   - one-cycle pulse, high in the first cycle level reads 1
module btn_debounce
  import pipeline_clk_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic sysclk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync_p0;
  logic            sync_p1;
  logic [DB_W-1:0] db_cnt_p2;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync_p0   <= 1'b0;
      sync_p1   <= 1'b0;
      db_cnt_p2 <= '0;
      level     <= 1'b0;
      rise      <= 1'b0;
    end else begin
      // stage p0/p1: metastability filter
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // stage p2: level only follows after DB_CYCLES consecutive mismatches;
      // a single matching sample restarts the run
      rise <= 1'b0;
      if (sync_p1 != level) begin
        if (db_cnt_p2 == DB_LAST) begin
          level     <= sync_p1;
          rise      <= sync_p1;
          db_cnt_p2 <= '0;
        end else begin
          db_cnt_p2 <= db_cnt_p2 + DB_W'(1);
        end
      end else begin
        db_cnt_p2 <= '0;
      end
    end
  end

endmodule

// File: rtl/pipeline_clk_ctrl.sv
// CPU clock-enable controller: free-run divider, debounced single-step and
// halt/resume handling. cpu_ce is registered; the tick decision is made one
// cycle ahead, so a tick is only scheduled when the FSM will still be in the
// issuing state when the pulse becomes visible.
// Ports:
//   sysclk     - system clock, rising edge
//   reset      - asynchronous active-high reset
//   mode_run   - 1 = free-run, 0 = single-step
//   step_btn   - raw step push-button
//   halt_req   - halt request from CPU (level)
//   resume     - resume request (level)
//   cpu_ce     - one-cycle CPU clock enable per tick
//   state      - FSM state (IDLE=0, RUN=1, STEP=2, HALT=3)
//   tick_count - cpu_ce pulses issued since reset (wraps)
module pipeline_clk_ctrl
  import pipeline_clk_ctrl_pkg::*;
#(
  parameter int DIV       = DEF_DIV,
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              mode_run,
  input  logic              step_btn,
  input  logic              halt_req,
  input  logic              resume,
  output logic              cpu_ce,
  output logic [1:0]        state,
  output logic [TICK_W-1:0] tick_count
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  clk_state_t       state_q;
  clk_state_t       state_d;
  logic [CNT_W-1:0] div_cnt;
  logic             btn_level;
  logic             btn_rise;
  logic             tick;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn (
    .sysclk (sysclk),
    .reset  (reset),
    .raw    (step_btn),
    .level  (btn_level),
    .rise   (btn_rise)
  );

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // halt_req outranks any mode_run change
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = mode_run ? ST_RUN : ST_STEP;
      ST_RUN: begin
        if (halt_req)      state_d = ST_HALT;
        else if (!mode_run) state_d = ST_STEP;
      end
      ST_STEP: begin
        if (halt_req)     state_d = ST_HALT;
        else if (mode_run) state_d = ST_RUN;
      end
      ST_HALT: if (resume && !halt_req) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Ticks are scheduled only when the FSM stays put, so HALT never sees a
  // pulse and a mode switch never emits a partial tick. Presses seen outside
  // STEP are simply dropped.
  always_comb begin
    tick = 1'b0;
    case (state_q)
      ST_RUN:  tick = (div_cnt == DIV_LAST) && mode_run && !halt_req;
      ST_STEP: tick = btn_rise && btn_level && !mode_run && !halt_req;
      default: tick = 1'b0;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (state_q == ST_RUN && state_d == ST_RUN) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + CNT_W'(1);
    end else begin
      div_cnt <= '0;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cpu_ce     <= 1'b0;
      tick_count <= '0;
    end else begin
      cpu_ce <= tick;
      if (tick) tick_count <= tick_count + TICK_W'(1);
    end
  end

  assign state = state_q;

endmodule
